light_seq_ctrl: RTL and testbench
=================================

// Module: light_seq_ctrl
// PURPOSE
//  Moore FSM that sequences the countdown timer for one traffic-light approach.
//  Each phase: pulses timer load with the phase colour, waits for expiry (timer==0), advances.
//  Adds pedestrian green cut-short and night-mode flashing yellow.
//  Sits between top-level inputs and the timer instance. Drives the lamps directly.
// PARAMETERS
//  ONE_SECOND  1   clk cycles per second; must equal the timer instance value
//  GREEN_TIME  15  green duration, seconds; must equal the timer instance value
//  MIN_GREEN   5   seconds of green that must elapse before a ped request may cut green; < GREEN_TIME
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  ped_req      in   1   pedestrian button; any-length pulse, latched internally
//  night_mode   in   1   level; sampled only at phase expiry
//  timer        in   32  remaining clk ticks from timer instance
//  load         out  1   to timer load; 1-cycle pulse at start of each phase
//  cur_state    out  2   to timer current_state: GREEN=00, YELLOW=01, RED=10
//  lamp_g       out  1   green lamp
//  lamp_y       out  1   yellow lamp
//  lamp_r       out  1   red lamp
//  ped_walk     out  1   walk signal
//  ped_pending  out  1   latched, not-yet-served ped request
// BEHAVIOUR
//  States, as {colour, phase}: colour in {G, Y, R, F}; phase in {LOAD, RUN}. All outputs decode from state regs plus ped_pending/flash_on regs.
//  Reset (async): state=R_LOAD, ped_pending=0, flash_on=0.
//    During and right after reset: load=1, cur_state=10, lamp_r=1, all other outputs 0.
//  LOAD: load=1 for exactly 1 cycle, then RUN unconditionally.
//    The timer is still stale in LOAD and is ignored.
//  RUN: load=0. Expiry = timer==0 in RUN; on expiry, go to next LOAD on the next edge.
//    G->Y, Y->R, R->G.
//    If night_mode=1 at any expiry: go to F_LOAD instead.
//  Phase length = TIME*ONE_SECOND + 2 cycles (1 LOAD cycle + RUN while timer counts full..0).
//  cur_state: G=00, Y=01, R=10, F=01 (flash reuses the yellow duration).
//  Lamps: G -> lamp_g; Y -> lamp_y; R -> lamp_r; F -> lamp_y=flash_on, lamp_g=lamp_r=0.
//    Exactly one lamp is high outside F.
//  Pedestrian:
//    ped_pending sets on ped_req=1 in colours G or Y.
//    ped_req is ignored in R and F.
//    Cleared on the edge entering R_LOAD; clear wins over a simultaneous set.
//    Held 0 in F.
//    In G_RUN, if ped_pending=1 and timer <= (GREEN_TIME-MIN_GREEN)*ONE_SECOND and timer != 0: go to Y_LOAD next edge (early exit).
//    Before that threshold the request waits.
//  ped_walk=1 in both phases of R if entered from Y; 0 otherwise.
//  Flash:
//    flash_on set 1 on entering F_LOAD.
//    At each F expiry: if night_mode=1, toggle flash_on and go to F_LOAD; else go to R_LOAD.
//    Exit from F is always via R.
//  Reset mid-phase: immediate return to the reset values above; the timer restarts from R_LOAD.
//  Comparisons are unsigned 32-bit. The threshold is computed at elaboration.
// TESTING (ONE_SECOND=1, GREEN=15, YELLOW=3, RED=18, MIN_GREEN=5)
//  1. Release rst, idle inputs
//     -> lamps R 20 cyc, G 17, Y 5, R 20, repeating.
//     -> load high exactly 1 cycle at each colour change; cur_state matches the colour.
//  2. ped_req 1-cycle pulse while timer=13 in G_RUN
//     -> ped_pending=1; G held until timer=10; Y_LOAD next cycle.
//     -> During the following R: ped_walk=1 for all 20 cycles; ped_pending=0 from R_LOAD.
//  3. ped_req pulses during R
//     -> ped_pending stays 0; R lasts the full 20 cycles.
//  4. ped_req high on the same cycle as the Y->R_LOAD edge
//     -> ped_pending=0 after the edge.
//  5. night_mode=1 mid-G
//     -> G runs to expiry, then F: lamp_y pattern 1,0,1,... every 5 cycles, lamp_g=lamp_r=0.
//     -> Drop night_mode -> next F expiry goes to R_LOAD, lamp_r=1.
//  6. rst pulse mid-Y_RUN
//     -> same cycle: lamp_r=1, lamp_y=0, load=1, ped_pending=0.
//     -> After release: R of 20 cycles, then normal sequence.

Source files
------------

// File: rtl/light_seq_ctrl.sv
// Phase sequencer for one traffic-light approach: pulses the countdown timer load,
// drives the lamps, and handles pedestrian green cut-short and night-mode flashing.
module light_seq_ctrl #(
    parameter int unsigned ONE_SECOND = 1,
    parameter int unsigned GREEN_TIME = 15,
    parameter int unsigned MIN_GREEN  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ped_req,
    input  logic        night_mode,
    input  logic [31:0] timer,
    output logic        load,
    output logic [1:0]  cur_state,
    output logic        lamp_g,
    output logic        lamp_y,
    output logic        lamp_r,
    output logic        ped_walk,
    output logic        ped_pending
);
    localparam int unsigned TIMER_W = 32;
    // Remaining-ticks level at or below which a pending walk request may cut green
    localparam logic [TIMER_W-1:0] PED_THRESH = TIMER_W'((GREEN_TIME - MIN_GREEN) * ONE_SECOND);

    typedef enum logic [2:0] {
        G_LOAD, G_RUN, Y_LOAD, Y_RUN, R_LOAD, R_RUN, F_LOAD, F_RUN
    } state_t;

    state_t     state_q, state_d;
    logic       flash_q, flash_d;
    logic       walk_q, walk_d;
    logic       pend_d;
    logic       expired, in_gy, in_f_d;
    logic       load_d, lamp_g_d, lamp_y_d, lamp_r_d, ped_walk_d;
    logic [1:0] cur_state_d;

    // Next state, pedestrian/flash bookkeeping and decoded outputs
    always_comb begin
        state_d     = state_q;
        flash_d     = flash_q;
        walk_d      = walk_q;
        pend_d      = ped_pending;
        expired     = (timer == '0);
        in_gy       = (state_q == G_LOAD) || (state_q == G_RUN) ||
                      (state_q == Y_LOAD) || (state_q == Y_RUN);
        in_f_d      = 1'b0;
        load_d      = 1'b0;
        cur_state_d = 2'b10;
        lamp_g_d    = 1'b0;
        lamp_y_d    = 1'b0;
        lamp_r_d    = 1'b0;
        ped_walk_d  = 1'b0;

        case (state_q)
            G_LOAD: state_d = G_RUN;
            G_RUN: begin
                if (expired) begin
                    if (night_mode) state_d = F_LOAD;
                    else            state_d = Y_LOAD;
                end else if (ped_pending && (timer <= PED_THRESH)) begin
                    state_d = Y_LOAD;
                end
            end
            Y_LOAD: state_d = Y_RUN;
            Y_RUN: begin
                if (expired) begin
                    if (night_mode) state_d = F_LOAD;
                    else            state_d = R_LOAD;
                end
            end
            R_LOAD: state_d = R_RUN;
            R_RUN: begin
                if (expired) begin
                    if (night_mode) state_d = F_LOAD;
                    else            state_d = G_LOAD;
                end
            end
            F_LOAD: state_d = F_RUN;
            F_RUN: begin
                if (expired) begin
                    if (night_mode) state_d = F_LOAD;
                    else            state_d = R_LOAD;
                end
            end
            default: state_d = R_LOAD;
        endcase

        in_f_d = (state_d == F_LOAD) || (state_d == F_RUN);

        // Entering red clears the request (clear beats a same-cycle set); flash holds it at 0
        if (ped_req && in_gy) pend_d = 1'b1;
        if ((state_d == R_LOAD) || in_f_d) pend_d = 1'b0;

        if (state_d == R_LOAD) walk_d = (state_q == Y_RUN);

        if (state_d == F_LOAD) flash_d = (state_q == F_RUN) ? ~flash_q : 1'b1;

        load_d = (state_d == G_LOAD) || (state_d == Y_LOAD) ||
                 (state_d == R_LOAD) || (state_d == F_LOAD);

        case (state_d)
            G_LOAD, G_RUN: begin
                cur_state_d = 2'b00;
                lamp_g_d    = 1'b1;
            end
            Y_LOAD, Y_RUN: begin
                cur_state_d = 2'b01;
                lamp_y_d    = 1'b1;
            end
            R_LOAD, R_RUN: begin
                cur_state_d = 2'b10;
                lamp_r_d    = 1'b1;
                ped_walk_d  = walk_d;
            end
            default: begin
                cur_state_d = 2'b01;
                lamp_y_d    = flash_d;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= R_LOAD;
            flash_q     <= 1'b0;
            walk_q      <= 1'b0;
            ped_pending <= 1'b0;
            load        <= 1'b1;
            cur_state   <= 2'b10;
            lamp_g      <= 1'b0;
            lamp_y      <= 1'b0;
            lamp_r      <= 1'b1;
            ped_walk    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flash_q     <= flash_d;
            walk_q      <= walk_d;
            ped_pending <= pend_d;
            load        <= load_d;
            cur_state   <= cur_state_d;
            lamp_g      <= lamp_g_d;
            lamp_y      <= lamp_y_d;
            lamp_r      <= lamp_r_d;
            ped_walk    <= ped_walk_d;
        end
    end

endmodule

// File: tb/tb_light_seq_ctrl.sv
// Bench for light_seq_ctrl: a countdown-timer stand-in plus a phase/age reference
// model of the light cycle, driven by directed scenarios then random inputs.
module tb_light_seq_ctrl;
    localparam int unsigned ONE_SECOND = 1;
    localparam int unsigned GREEN_T    = 15;
    localparam int unsigned YELLOW_T   = 3;
    localparam int unsigned RED_T      = 18;
    localparam int unsigned MIN_G      = 5;

    localparam int COL_G = 0;
    localparam int COL_Y = 1;
    localparam int COL_R = 2;
    localparam int COL_F = 3;

    localparam int W_G = 0;
    localparam int W_Y = 1;
    localparam int W_R = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ped_req;
    logic        night_mode;
    logic [31:0] timer = '0;
    logic        load;
    logic [1:0]  cur_state;
    logic        lamp_g, lamp_y, lamp_r, ped_walk, ped_pending;

    int checks = 0;
    int errors = 0;

    int   m_col;
    int   m_age;
    logic m_pend, m_walk, m_flash;

    light_seq_ctrl #(
        .ONE_SECOND(ONE_SECOND),
        .GREEN_TIME(GREEN_T),
        .MIN_GREEN (MIN_G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ped_req    (ped_req),
        .night_mode (night_mode),
        .timer      (timer),
        .load       (load),
        .cur_state  (cur_state),
        .lamp_g     (lamp_g),
        .lamp_y     (lamp_y),
        .lamp_r     (lamp_r),
        .ped_walk   (ped_walk),
        .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    // Stand-in for the countdown timer instance
    always @(posedge clk) begin
        if (load) begin
            case (cur_state)
                2'b00:   timer <= GREEN_T * ONE_SECOND;
                2'b01:   timer <= YELLOW_T * ONE_SECOND;
                default: timer <= RED_T * ONE_SECOND;
            endcase
        end else if (timer != 0) begin
            timer <= timer - 1;
        end
    end

    function automatic int plen(input int c);
        case (c)
            COL_G:   return int'(GREEN_T * ONE_SECOND) + 2;
            COL_R:   return int'(RED_T * ONE_SECOND) + 2;
            default: return int'(YELLOW_T * ONE_SECOND) + 2;
        endcase
    endfunction

    function automatic logic [31:0] col_code(input int c);
        case (c)
            COL_G:   return 32'd0;
            COL_R:   return 32'd2;
            default: return 32'd1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col   = COL_R;
        m_age   = 0;
        m_pend  = 1'b0;
        m_walk  = 1'b0;
        m_flash = 1'b0;
    endtask

    task automatic check_model();
        check("load",        32'(load),        32'(m_age == 0));
        check("cur_state",   32'(cur_state),   col_code(m_col));
        check("lamp_g",      32'(lamp_g),      32'(m_col == COL_G));
        check("lamp_y",      32'(lamp_y),      32'((m_col == COL_Y) || ((m_col == COL_F) && m_flash)));
        check("lamp_r",      32'(lamp_r),      32'(m_col == COL_R));
        check("ped_walk",    32'(ped_walk),    32'((m_col == COL_R) && m_walk));
        check("ped_pending", 32'(ped_pending), 32'(m_pend));
    endtask

    // One cycle of the light's rules: phases of fixed length, green cut short once
    // MIN_G seconds of green have elapsed with a pending request.
    task automatic model_advance(input logic p, input logic n);
        logic expiry, early, new_phase, np;
        int   nxt;
        expiry    = (m_age == plen(m_col) - 1);
        early     = (m_col == COL_G) && m_pend && !expiry &&
                    (m_age >= int'(MIN_G * ONE_SECOND) + 1);
        new_phase = expiry || early;
        np        = m_pend | (p && ((m_col == COL_G) || (m_col == COL_Y)));
        nxt       = m_col;
        if (expiry) begin
            if (n) begin
                m_flash = (m_col == COL_F) ? ~m_flash : 1'b1;
                nxt     = COL_F;
            end else if (m_col == COL_F) begin
                nxt = COL_R;
            end else if (m_col == COL_R) begin
                nxt = COL_G;
            end else begin
                nxt = m_col + 1;
            end
        end else if (early) begin
            nxt = COL_Y;
        end
        if (new_phase && (nxt == COL_R)) begin
            np     = 1'b0;
            m_walk = (m_col == COL_Y);
        end
        if (nxt == COL_F) np = 1'b0;
        m_col  = nxt;
        m_age  = new_phase ? 0 : m_age + 1;
        m_pend = np;
    endtask

    task automatic step(input logic p, input logic n);
        ped_req    = p;
        night_mode = n;
        check_model();
        if (rst) model_reset();
        else     model_advance(p, n);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Idle until a given colour (RUN phase at a timer value, or red LOAD) is showing
    task automatic wait_for(input int which, input logic [31:0] tv);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            case (which)
                W_G:     found = lamp_g && !load && (timer == tv);
                W_Y:     found = lamp_y && !load && (timer == tv);
                default: found = lamp_r && load;
            endcase
            if (found) break;
            step(1'b0, night_mode);
        end
        check("wait_event", 32'(found), 32'd1);
    endtask

    initial begin
        logic nm;
        rst        = 1'b1;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) step(1'b0, 1'b0);
        rst = 1'b0;

        // Idle cycling R/G/Y
        repeat (90) step(1'b0, 1'b0);

        // Walk request mid-green: cut short at the threshold, walk through red
        wait_for(W_G, 32'd13);
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);

        // Requests during red are ignored
        wait_for(W_R, 32'd0);
        repeat (8) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        repeat (10) step(1'b0, 1'b0);

        // Request on the yellow-to-red edge is cleared
        wait_for(W_Y, 32'd0);
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);

        // Night mode raised mid-green, then dropped
        wait_for(W_G, 32'd10);
        repeat (40) step(1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0);

        // Asynchronous reset in yellow with a request pending
        wait_for(W_G, 32'd14);
        step(1'b1, 1'b0);
        wait_for(W_Y, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_load",    32'(load),        32'd1);
        check("async_rst_lamp_r",  32'(lamp_r),      32'd1);
        check("async_rst_lamp_y",  32'(lamp_y),      32'd0);
        check("async_rst_pending", 32'(ped_pending), 32'd0);
        check("async_rst_state",   32'(cur_state),   32'd2);
        model_reset();
        @(negedge clk);
        repeat (2) step(1'b0, 1'b0);
        rst = 1'b0;
        repeat (60) step(1'b0, 1'b0);

        // Random pedestrian and night-mode activity
        nm = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) nm = ~nm;
            step(logic'($urandom_range(0, 7) == 0), nm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
